reg_wr_decoder: RTL and testbench

Parametrised write-enable decoder and scoreboard for the register bank. It is the registered successor to the fixed 4-to-16 enable decoder. It accepts two write ports, decodes each address into a one-hot enable, and resolves same-register collisions. It also tracks pending (issued but not yet written) registers so that read-hazard checks can be made, and sits between the issue/write-back logic and the register array.

---
 rtl/reg_bank_pkg.sv | 11 +
 rtl/onehot_dec.sv | 20 ++
 rtl/reg_wr_decoder.sv | 98 +++++++++
 tb/tb_reg_wr_decoder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared constants and helpers for the register-bank write path.
package reg_bank_pkg;

  localparam int unsigned DefAddrW = 4;
  localparam int unsigned ZeroReg  = 0;

  function automatic int unsigned num_regs(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Combinational address to one-hot decoder, gated by an enable.
module onehot_dec
  import reg_bank_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  localparam int unsigned NumOut = num_regs(ADDR_W)
) (
  input  logic              en_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [NumOut-1:0] dec_o
);

  always_comb begin
    dec_o = '0;
    for (int unsigned i = 0; i < NumOut; i++) begin
      dec_o[i] = en_i && (addr_i == ADDR_W'(i));
    end
  end

endmodule

// File: rtl/reg_wr_decoder.sv
// Registered two-port write-enable decoder with collision resolution and a
// pending-register scoreboard for read-hazard checks.
module reg_wr_decoder
  import reg_bank_pkg::*;
#(
  parameter int unsigned ADDR_W      = DefAddrW,
  parameter bit          ZERO_REG_RO = 1'b1,
  localparam int unsigned NUM_REGS   = num_regs(ADDR_W)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en_a,
  input  logic [ADDR_W-1:0]   wr_addr_a,
  input  logic                wr_en_b,
  input  logic [ADDR_W-1:0]   wr_addr_b,
  input  logic                issue_en,
  input  logic [ADDR_W-1:0]   issue_addr,
  input  logic [ADDR_W-1:0]   rd_addr_a,
  input  logic [ADDR_W-1:0]   rd_addr_b,
  output logic [NUM_REGS-1:0] reg_we,
  output logic [NUM_REGS-1:0] sel_b,
  output logic                conflict,
  output logic [NUM_REGS-1:0] pend,
  output logic                hazard_a,
  output logic                hazard_b
);

  localparam logic [ADDR_W-1:0] ZeroIdx = ADDR_W'(ZeroReg);

  logic [NUM_REGS-1:0] dec_a, dec_b, dec_i;
  logic [NUM_REGS-1:0] zero_mask;
  logic [NUM_REGS-1:0] acc_a, acc_b, acc_i, win_b;
  logic [NUM_REGS-1:0] reg_we_d, reg_we_q;
  logic [NUM_REGS-1:0] sel_b_d, sel_b_q;
  logic [NUM_REGS-1:0] pend_d, pend_q;
  logic                conflict_d, conflict_q;

  onehot_dec #(.ADDR_W(ADDR_W)) u_dec_a (
    .en_i   (wr_en_a),
    .addr_i (wr_addr_a),
    .dec_o  (dec_a)
  );

  onehot_dec #(.ADDR_W(ADDR_W)) u_dec_b (
    .en_i   (wr_en_b),
    .addr_i (wr_addr_b),
    .dec_o  (dec_b)
  );

  onehot_dec #(.ADDR_W(ADDR_W)) u_dec_i (
    .en_i   (issue_en),
    .addr_i (issue_addr),
    .dec_o  (dec_i)
  );

  always_comb begin
    zero_mask = '1;
    if (ZERO_REG_RO) begin
      zero_mask[ZeroIdx] = 1'b0;
    end
  end

  // Masking happens before collision detection so a clash on a read-only
  // register never reports a conflict.
  always_comb begin
    acc_a      = dec_a & zero_mask;
    acc_b      = dec_b & zero_mask;
    acc_i      = dec_i & zero_mask;
    win_b      = acc_b & ~acc_a;
    reg_we_d   = acc_a | win_b;
    sel_b_d    = win_b;
    conflict_d = |(acc_a & acc_b);
    // A same-cycle issue supersedes the write that would clear the bit.
    pend_d     = (pend_q & ~reg_we_d) | acc_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_we_q   <= '0;
      sel_b_q    <= '0;
      conflict_q <= 1'b0;
      pend_q     <= '0;
    end else begin
      reg_we_q   <= reg_we_d;
      sel_b_q    <= sel_b_d;
      conflict_q <= conflict_d;
      pend_q     <= pend_d;
    end
  end

  assign reg_we   = reg_we_q;
  assign sel_b    = sel_b_q;
  assign conflict = conflict_q;
  assign pend     = pend_q;
  assign hazard_a = pend_q[rd_addr_a];
  assign hazard_b = pend_q[rd_addr_b];

endmodule

// File: tb/tb_reg_wr_decoder.sv
// Bench for reg_wr_decoder: one instance with register 0 read-only, one
// without, driven in lockstep and compared against a behavioural model.
module tb_reg_wr_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en_a, wr_en_b, issue_en;
  logic [3:0] wr_addr_a, wr_addr_b, issue_addr, rd_addr_a, rd_addr_b;

  logic [15:0] reg_we_ro, sel_b_ro, pend_ro;
  logic        conflict_ro, hazard_a_ro, hazard_b_ro;
  logic [15:0] reg_we_rw, sel_b_rw, pend_rw;
  logic        conflict_rw, hazard_a_rw, hazard_b_rw;

  int checks = 0;
  int errors = 0;

  // Reference state: index 0 models the read-only-zero instance, 1 the other.
  bit pend_m [2][16];

  always #5 clk = ~clk;

  reg_wr_decoder #(.ADDR_W(4), .ZERO_REG_RO(1'b1)) u_ro (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_a    (wr_en_a),
    .wr_addr_a  (wr_addr_a),
    .wr_en_b    (wr_en_b),
    .wr_addr_b  (wr_addr_b),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .reg_we     (reg_we_ro),
    .sel_b      (sel_b_ro),
    .conflict   (conflict_ro),
    .pend       (pend_ro),
    .hazard_a   (hazard_a_ro),
    .hazard_b   (hazard_b_ro)
  );

  reg_wr_decoder #(.ADDR_W(4), .ZERO_REG_RO(1'b0)) u_rw (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_a    (wr_en_a),
    .wr_addr_a  (wr_addr_a),
    .wr_en_b    (wr_en_b),
    .wr_addr_b  (wr_addr_b),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .reg_we     (reg_we_rw),
    .sel_b      (sel_b_rw),
    .conflict   (conflict_rw),
    .pend       (pend_rw),
    .hazard_a   (hazard_a_rw),
    .hazard_b   (hazard_b_rw)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pend_vec(input int r);
    logic [15:0] v = '0;
    for (int i = 0; i < 16; i++) v[i] = pend_m[r][i];
    return v;
  endfunction

  function automatic bit allowed(input int r, input logic en, input logic [3:0] addr);
    // Instance 0 discards anything aimed at register 0.
    return en && !(r == 0 && addr == 4'd0);
  endfunction

  task automatic clear_model();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 16; i++) pend_m[r][i] = 1'b0;
  endtask

  // One clock of stimulus: hazards checked before the edge, registered
  // outputs checked just after it.
  task automatic drive(input logic ea, input logic [3:0] aa, input logic eb,
                       input logic [3:0] ab, input logic ei, input logic [3:0] ai,
                       input logic [3:0] ra, input logic [3:0] rb);
    logic [15:0] e_we [2];
    logic [15:0] e_sel [2];
    logic        e_cf [2];
    bit          ok_a, ok_b, ok_i;
    wr_en_a = ea; wr_addr_a = aa; wr_en_b = eb; wr_addr_b = ab;
    issue_en = ei; issue_addr = ai; rd_addr_a = ra; rd_addr_b = rb;
    #1;
    chk("hazard_a_ro", {15'b0, hazard_a_ro}, {15'b0, pend_m[0][ra]});
    chk("hazard_b_ro", {15'b0, hazard_b_ro}, {15'b0, pend_m[0][rb]});
    chk("hazard_a_rw", {15'b0, hazard_a_rw}, {15'b0, pend_m[1][ra]});
    chk("hazard_b_rw", {15'b0, hazard_b_rw}, {15'b0, pend_m[1][rb]});
    @(posedge clk);
    for (int r = 0; r < 2; r++) begin
      ok_a = allowed(r, ea, aa);
      ok_b = allowed(r, eb, ab);
      ok_i = allowed(r, ei, ai);
      e_we[r] = '0; e_sel[r] = '0;
      e_cf[r] = ok_a && ok_b && (aa == ab);
      if (ok_a) begin
        e_we[r][aa] = 1'b1;
        pend_m[r][aa] = 1'b0;
      end
      if (ok_b && !e_cf[r]) begin
        e_we[r][ab] = 1'b1;
        e_sel[r][ab] = 1'b1;
        pend_m[r][ab] = 1'b0;
      end
      if (ok_i) pend_m[r][ai] = 1'b1;
    end
    #1;
    chk("reg_we_ro", reg_we_ro, e_we[0]);
    chk("sel_b_ro", sel_b_ro, e_sel[0]);
    chk("conflict_ro", {15'b0, conflict_ro}, {15'b0, e_cf[0]});
    chk("pend_ro", pend_ro, pend_vec(0));
    chk("reg_we_rw", reg_we_rw, e_we[1]);
    chk("sel_b_rw", sel_b_rw, e_sel[1]);
    chk("conflict_rw", {15'b0, conflict_rw}, {15'b0, e_cf[1]});
    chk("pend_rw", pend_rw, pend_vec(1));
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we_ro"}, reg_we_ro, 16'h0);
    chk({tag, "_sel_ro"}, sel_b_ro, 16'h0);
    chk({tag, "_cf_ro"}, {15'b0, conflict_ro}, 16'h0);
    chk({tag, "_pend_ro"}, pend_ro, 16'h0);
    chk({tag, "_haz_ro"}, {14'b0, hazard_a_ro, hazard_b_ro}, 16'h0);
    chk({tag, "_we_rw"}, reg_we_rw, 16'h0);
    chk({tag, "_pend_rw"}, pend_rw, 16'h0);
    chk({tag, "_cf_rw"}, {15'b0, conflict_rw}, 16'h0);
  endtask

  initial begin
    logic [3:0] ra, rb, aa;
    rst_n = 1'b0;
    wr_en_a = 1'b0; wr_en_b = 1'b0; issue_en = 1'b0;
    wr_addr_a = '0; wr_addr_b = '0; issue_addr = '0; rd_addr_a = '0; rd_addr_b = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single write, then the enable must drop.
    drive(1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0);
    chk("single_we", reg_we_ro, 16'h0020);
    idle();
    chk("single_we_gone", reg_we_ro, 16'h0000);

    drive(1'b1, 4'd3, 1'b1, 4'd12, 1'b0, 4'd0, 4'd0, 4'd0);
    chk("dual_sel_b", sel_b_ro, 16'h1000);

    drive(1'b1, 4'd9, 1'b1, 4'd9, 1'b0, 4'd0, 4'd0, 4'd0);
    chk("clash_conflict", {15'b0, conflict_ro}, 16'h0001);
    drive(1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0);
    chk("clash_zero_ro", {15'b0, conflict_ro}, 16'h0000);
    chk("clash_zero_rw_we", reg_we_rw, 16'h0001);

    // Scoreboard set, hazard visible, cleared by a B write.
    drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd7, 4'd7, 4'd0);
    chk("issue_pend", pend_ro, 16'h0080);
    drive(1'b0, 4'd0, 1'b1, 4'd7, 1'b0, 4'd0, 4'd7, 4'd7);
    chk("write_clears", pend_ro, 16'h0000);
    // Same-cycle issue and write: issue wins.
    drive(1'b1, 4'd7, 1'b0, 4'd0, 1'b1, 4'd7, 4'd7, 4'd0);
    chk("issue_beats_write", pend_ro, 16'h0080);
    drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd7, 4'd7, 4'd0);
    // A dropped B write must not clear a pending register.
    drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd8, 4'd8, 4'd7);
    drive(1'b1, 4'd8, 1'b1, 4'd8, 1'b0, 4'd0, 4'd8, 4'd7);
    drive(1'b1, 4'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd7, 4'd8);

    // Register zero handling on both instances.
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b1, 4'd0, 4'd0, 4'd0);
    chk("zero_we_ro", reg_we_ro, 16'h0000);
    chk("zero_pend_rw", pend_rw, 16'h0001);
    drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0);
    chk("zero_haz_b_rw", {15'b0, hazard_b_rw}, 16'h0001);
    chk("zero_haz_b_ro", {15'b0, hazard_b_ro}, 16'h0000);
    drive(1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0);

    // Build up pend=0xF0 with a write in flight, then reset between edges.
    for (int i = 4; i < 8; i++) begin
      drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'(i), 4'd4, 4'd5);
    end
    drive(1'b1, 4'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd4, 4'd5);
    chk("pre_reset_pend", pend_ro, 16'h00F0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    clear_model();
    wr_en_a = 1'b1; wr_addr_a = 4'd3; issue_en = 1'b1; issue_addr = 4'd6;
    @(posedge clk);
    #1;
    chk_all_zero("in_reset");
    #2;
    rst_n = 1'b1;
    drive(1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 4'd0, 4'd6, 4'd3);
    chk("post_reset_we", reg_we_ro, 16'h0008);
    idle();

    // Randomised traffic with frequent address clashes.
    for (int n = 0; n < 400; n++) begin
      aa = 4'($urandom_range(0, 15));
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      drive(1'($urandom), aa, 1'($urandom),
            ($urandom_range(0, 2) == 0) ? aa : 4'($urandom_range(0, 15)),
            1'($urandom), 4'($urandom_range(0, 15)), ra, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
